frame_decode: RTL and testbench
===============================

FRAME_DECODE -- requirements
Module: frame_decode

Interface
REQ-001 SHALL have one clock and an asynchronous active-low reset: clk input 1 (13.56MHz recovered carrier clock, stops during pauses); rst_n input 1 (synchronised asynchronous reset, active low).
REQ-002 SHALL accept the per-bit stream produced by the sequence decoder on these inputs:
- in_soc input 1 (start of frame, 1-tick strobe)
- in_eoc input 1 (end of frame, 1-tick strobe)
- in_error input 1 (timing error, 1-tick strobe)
- in_data_valid input 1 (1-tick strobe)
- in_data input 1 (bit value, qualified by in_data_valid)
REQ-003 SHALL produce these outputs:
- out_soc output 1 (1-tick strobe)
- out_eoc output 1 (1-tick strobe)
- out_error output 1 (1-tick strobe)
- out_data_valid output 1 (1-tick strobe, complete byte)
- out_data output 8 (byte, LSB = first received bit)
- out_data_bits output 3 (bits in trailing partial byte, valid with out_eoc)
- out_byte_count output 6 (complete bytes in the frame, valid with out_eoc)

Function
REQ-004 SHALL register every output, so each response appears exactly 1 clk after the input strobe causing it.
REQ-005 SHALL implement states IDLE, DATA, PARITY, ERROR.
REQ-006 SHALL, in any state, on in_soc: clear bit counter, shift register and byte count; enter DATA; pulse out_soc. A second soc mid-frame restarts the frame with no eoc.
REQ-007 SHALL ignore in_data_valid, in_eoc and in_error in IDLE.
REQ-008 SHALL, in DATA on in_data_valid, shift in_data into bit position bit_cnt (LSB first), increment the 3-bit bit_cnt, and move to PARITY when the 8th bit arrives (bit_cnt wraps 7->0).
REQ-009 SHALL, in PARITY on in_data_valid, check odd parity (in_data == ~^byte):
- pass: pulse out_data_valid with out_data=byte, increment byte count (saturating at 63), return to DATA
- fail: pulse out_error, enter ERROR, emit no byte.
REQ-010 SHALL, in DATA on in_eoc, pulse out_eoc with out_data_bits=bit_cnt, out_data=partial byte with unreceived bits zero, and out_byte_count, then go to IDLE.
REQ-011 SHALL, in PARITY on in_eoc (8 bits, parity missing), pulse out_error and out_eoc together (out_data_bits=0) and go to IDLE.
REQ-012 SHALL, in DATA or PARITY on in_error, pulse out_error and enter ERROR.
REQ-013 SHALL, in ERROR, ignore data and further errors; on in_eoc pulse out_eoc only (out_data_bits=0, out_byte_count as accumulated) and go to IDLE.
REQ-014 SHALL, for simultaneous strobes, apply priority soc > error > eoc > data_valid; lower-priority strobes are dropped.
REQ-015 SHALL hold out_data, out_data_bits and out_byte_count stable between strobes; their values are undefined when not qualified.

Reset
REQ-016 SHALL, on rst_n low, immediately set state=IDLE, all strobe outputs=0, bit_cnt=0, byte count=0, out_data=0, out_data_bits=0, out_byte_count=0.
REQ-017 SHALL, after reset is released mid-frame, ignore everything until the next in_soc.

Structure
REQ-018 SHALL define the state enum (FrameDecodeState) in ISO14443A_pkg alongside PCDBitSequence.
REQ-019 SHALL be a single module with no sub-modules; the parity check is computed inline.

Verification
REQ-020 Short frame: soc, 7 bits of 0x26 (0,1,1,0,0,1,0), eoc -> out_soc; then out_eoc with out_data_bits=7, out_data=0x26, out_byte_count=0; no out_data_valid.
REQ-021 Standard frame: soc, 0x93+parity 1, 0x20+parity 0, eoc -> out_data_valid 0x93, out_data_valid 0x20, then out_eoc with bits=0, count=2.
REQ-022 Parity failure: soc, 0x93+parity 0, 0x20+parity 0, eoc -> out_error once, no out_data_valid, out_eoc with count=0.
REQ-023 Timing error: soc, 4 bits, in_error, 10 more bits, eoc -> out_error once, then out_eoc only; nothing in between.
REQ-024 Boundaries: 70 valid bytes -> out_byte_count=63 at eoc; soc and data_valid in the same tick -> only out_soc; eoc directly after the 8th bit -> out_error+out_eoc in the same tick.
REQ-025 Reset mid-frame: assert rst_n low after 12 bits, release, send bits and eoc with no soc -> all outputs stay 0.

Source files
------------

// File: rtl/ISO14443A_pkg.sv
// Shared ISO14443A reader-side types: PCD bit-sequence symbols and frame decoder states.
package ISO14443A_pkg;

    typedef enum logic [1:0] {
        SEQ_X,
        SEQ_Y,
        SEQ_Z,
        SEQ_ERR
    } PCDBitSequence;

    typedef enum logic [1:0] {
        FD_IDLE,
        FD_DATA,
        FD_PARITY,
        FD_ERROR
    } FrameDecodeState;

    localparam int              BYTE_CNT_W   = 6;
    localparam logic [BYTE_CNT_W-1:0] BYTE_CNT_MAX = '1;

endpackage

// File: rtl/frame_decode.sv
// Assembles the decoded PCD bit stream into odd-parity-checked bytes and
// reports frame start, end, errors and the trailing partial byte.
module frame_decode
    import ISO14443A_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_soc,
    input  logic       in_eoc,
    input  logic       in_error,
    input  logic       in_data_valid,
    input  logic       in_data,
    output logic       out_soc,
    output logic       out_eoc,
    output logic       out_error,
    output logic       out_data_valid,
    output logic [7:0] out_data,
    output logic [2:0] out_data_bits,
    output logic [5:0] out_byte_count
);

    FrameDecodeState         state;
    logic [2:0]              bit_cnt;
    logic [7:0]              shift_reg;
    logic [BYTE_CNT_W-1:0]   byte_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= FD_IDLE;
            bit_cnt        <= '0;
            shift_reg      <= '0;
            byte_cnt       <= '0;
            out_soc        <= 1'b0;
            out_eoc        <= 1'b0;
            out_error      <= 1'b0;
            out_data_valid <= 1'b0;
            out_data       <= '0;
            out_data_bits  <= '0;
            out_byte_count <= '0;
        end else begin
            out_soc        <= 1'b0;
            out_eoc        <= 1'b0;
            out_error      <= 1'b0;
            out_data_valid <= 1'b0;

            // soc overrides every state and every other strobe
            if (in_soc) begin
                bit_cnt   <= '0;
                shift_reg <= '0;
                byte_cnt  <= '0;
                state     <= FD_DATA;
                out_soc   <= 1'b1;
            end else begin
                case (state)
                    FD_IDLE: ;

                    FD_DATA: begin
                        if (in_error) begin
                            out_error <= 1'b1;
                            state     <= FD_ERROR;
                        end else if (in_eoc) begin
                            out_eoc        <= 1'b1;
                            out_data       <= shift_reg;
                            out_data_bits  <= bit_cnt;
                            out_byte_count <= byte_cnt;
                            state          <= FD_IDLE;
                        end else if (in_data_valid) begin
                            shift_reg[bit_cnt] <= in_data;
                            bit_cnt            <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7)
                                state <= FD_PARITY;
                        end
                    end

                    FD_PARITY: begin
                        if (in_error) begin
                            out_error <= 1'b1;
                            state     <= FD_ERROR;
                        end else if (in_eoc) begin
                            out_error      <= 1'b1;
                            out_eoc        <= 1'b1;
                            out_data_bits  <= '0;
                            out_byte_count <= byte_cnt;
                            state          <= FD_IDLE;
                        end else if (in_data_valid) begin
                            if (in_data == ~^shift_reg) begin
                                out_data_valid <= 1'b1;
                                out_data       <= shift_reg;
                                if (byte_cnt != BYTE_CNT_MAX)
                                    byte_cnt <= byte_cnt + 1'b1;
                                // next byte is built on a clean register so a
                                // partial trailing byte reads zero above bit_cnt
                                shift_reg <= '0;
                                state     <= FD_DATA;
                            end else begin
                                out_error <= 1'b1;
                                state     <= FD_ERROR;
                            end
                        end
                    end

                    FD_ERROR: begin
                        if (in_eoc) begin
                            out_eoc        <= 1'b1;
                            out_data_bits  <= '0;
                            out_byte_count <= byte_cnt;
                            state          <= FD_IDLE;
                        end
                    end

                    default: state <= FD_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_frame_decode.sv
// Bench for frame_decode: vector table, directed frame sequences and a
// randomized stream checked against a bit-queue reference model.
module tb_frame_decode;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_soc, in_eoc, in_error, in_data_valid, in_data;
    logic       out_soc, out_eoc, out_error, out_data_valid;
    logic [7:0] out_data;
    logic [2:0] out_data_bits;
    logic [5:0] out_byte_count;

    frame_decode dut (
        .clk(clk), .rst_n(rst_n),
        .in_soc(in_soc), .in_eoc(in_eoc), .in_error(in_error),
        .in_data_valid(in_data_valid), .in_data(in_data),
        .out_soc(out_soc), .out_eoc(out_eoc), .out_error(out_error),
        .out_data_valid(out_data_valid), .out_data(out_data),
        .out_data_bits(out_data_bits), .out_byte_count(out_byte_count)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: frame is a queue of received bits of the current byte
    bit m_act, m_err;
    int mq[$];
    int m_cnt;

    bit         x_soc, x_eoc, x_err, x_dv, x_dchk;
    logic [7:0] x_data;
    int         x_bits, x_cnt;

    int n_soc, n_eoc, n_err, n_dv;
    bit saw_err_eoc;
    logic [7:0] dv_q[$];
    int last_bits, last_cnt;
    logic [7:0] last_eoc_data;

    function automatic logic [7:0] assemble(int n);
        logic [7:0] v = 8'h00;
        for (int i = 0; i < n; i++)
            if (mq[i] != 0) v = v | (8'h01 << i);
        return v;
    endfunction

    function automatic void model_reset();
        m_act = 0; m_err = 0; mq.delete(); m_cnt = 0;
    endfunction

    function automatic void model_step(bit s, bit e, bit er, bit v, bit d);
        int ones;
        x_soc = 0; x_eoc = 0; x_err = 0; x_dv = 0; x_dchk = 0;
        x_data = 8'h00; x_bits = 0; x_cnt = 0;
        if (s) begin
            m_act = 1; m_err = 0; mq.delete(); m_cnt = 0; x_soc = 1;
        end else if (m_err) begin
            if (e) begin
                x_eoc = 1; x_bits = 0; x_cnt = m_cnt; m_err = 0;
            end
        end else if (m_act) begin
            if (er) begin
                x_err = 1; m_err = 1; m_act = 0;
            end else if (e) begin
                x_eoc = 1; x_cnt = m_cnt; m_act = 0;
                if (mq.size() == 8) begin
                    x_err = 1; x_bits = 0;
                end else begin
                    x_bits = mq.size(); x_data = assemble(mq.size()); x_dchk = 1;
                end
            end else if (v) begin
                mq.push_back(int'(d));
                if (mq.size() == 9) begin
                    ones = 0;
                    foreach (mq[i]) ones += mq[i];
                    if (ones % 2 == 1) begin
                        x_dv = 1; x_data = assemble(8);
                        if (m_cnt < 63) m_cnt++;
                        mq.delete();
                    end else begin
                        x_err = 1; m_err = 1; m_act = 0;
                    end
                end
            end
        end
    endfunction

    task automatic tick(input bit s, input bit e, input bit er, input bit v, input bit d);
        bit ok;
        @(negedge clk);
        in_soc = s; in_eoc = e; in_error = er; in_data_valid = v; in_data = d;
        model_step(s, e, er, v, d);
        @(posedge clk);
        #1;
        in_soc = 0; in_eoc = 0; in_error = 0; in_data_valid = 0; in_data = 0;
        tests++;
        ok = (out_soc == x_soc) && (out_eoc == x_eoc) && (out_error == x_err) &&
             (out_data_valid == x_dv);
        if (x_dv && out_data !== x_data) ok = 0;
        if (x_dchk && out_data !== x_data) ok = 0;
        if (x_eoc && (int'(out_data_bits) != x_bits || int'(out_byte_count) != x_cnt)) ok = 0;
        if (!ok) begin
            fails++;
            $display("FAIL model t=%0t got soc=%0b eoc=%0b err=%0b dv=%0b data=%02h bits=%0d cnt=%0d exp soc=%0b eoc=%0b err=%0b dv=%0b data=%02h bits=%0d cnt=%0d",
                     $time, out_soc, out_eoc, out_error, out_data_valid, out_data,
                     out_data_bits, out_byte_count, x_soc, x_eoc, x_err, x_dv, x_data,
                     x_bits, x_cnt);
        end
        if (out_soc) n_soc++;
        if (out_error) n_err++;
        if (out_eoc) begin
            n_eoc++; last_bits = int'(out_data_bits); last_cnt = int'(out_byte_count);
            last_eoc_data = out_data;
        end
        if (out_data_valid) begin
            n_dv++; dv_q.push_back(out_data);
        end
        if (out_error && out_eoc) saw_err_eoc = 1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s got %0d exp %0d", name, act, exp);
        end
    endtask

    task automatic clr_ev();
        n_soc = 0; n_eoc = 0; n_err = 0; n_dv = 0; saw_err_eoc = 0; dv_q.delete();
        last_bits = -1; last_cnt = -1; last_eoc_data = 8'hxx;
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 0, 1, b[i]);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit p);
        send_bits(b, 8);
        tick(0, 0, 0, 1, p);
    endtask

    function automatic int all_outs();
        return int'({out_soc, out_eoc, out_error, out_data_valid, out_data,
                     out_data_bits, out_byte_count});
    endfunction

    typedef struct {
        bit s, e, er, v, d;
        bit es, ee, eer, edv;
        logic [7:0] edata;
        int ebits, ecnt;
        bit dchk;
    } vec_t;

    vec_t tbl[16];

    initial begin
        bit s, e, er, v, d;
        int ones;

        tbl[0]  = '{1,0,0,0,0, 1,0,0,0, 8'h00,0,0,0};
        tbl[1]  = '{0,0,0,1,0, 0,0,0,0, 8'h00,0,0,0};
        tbl[2]  = '{0,0,0,1,1, 0,0,0,0, 8'h00,0,0,0};
        tbl[3]  = '{0,0,0,1,1, 0,0,0,0, 8'h00,0,0,0};
        tbl[4]  = '{0,0,0,1,0, 0,0,0,0, 8'h00,0,0,0};
        tbl[5]  = '{0,0,0,1,0, 0,0,0,0, 8'h00,0,0,0};
        tbl[6]  = '{0,0,0,1,1, 0,0,0,0, 8'h00,0,0,0};
        tbl[7]  = '{0,0,0,1,0, 0,0,0,0, 8'h00,0,0,0};
        tbl[8]  = '{0,1,0,0,0, 0,1,0,0, 8'h26,7,0,1};
        tbl[9]  = '{1,0,0,1,1, 1,0,0,0, 8'h00,0,0,0};
        tbl[10] = '{0,1,0,0,0, 0,1,0,0, 8'h00,0,0,1};
        tbl[11] = '{1,0,0,0,0, 1,0,0,0, 8'h00,0,0,0};
        tbl[12] = '{0,1,1,0,0, 0,0,1,0, 8'h00,0,0,0};
        tbl[13] = '{0,1,0,0,0, 0,1,0,0, 8'h00,0,0,0};
        tbl[14] = '{0,0,0,1,1, 0,0,0,0, 8'h00,0,0,0};
        tbl[15] = '{0,1,0,0,0, 0,0,0,0, 8'h00,0,0,0};

        rst_n = 0;
        in_soc = 0; in_eoc = 0; in_error = 0; in_data_valid = 0; in_data = 0;
        model_reset();
        clr_ev();
        #1;
        check("reset_outputs_immediate", all_outs(), 0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(posedge clk); #1;
        check("reset_outputs_after_release", all_outs(), 0);

        // Vector table: short frame, soc+data_valid collision, error+eoc collision, idle
        for (int k = 0; k < 16; k++) begin
            bit ok;
            tick(tbl[k].s, tbl[k].e, tbl[k].er, tbl[k].v, tbl[k].d);
            ok = (out_soc == tbl[k].es) && (out_eoc == tbl[k].ee) &&
                 (out_error == tbl[k].eer) && (out_data_valid == tbl[k].edv);
            if (tbl[k].ee && (int'(out_data_bits) != tbl[k].ebits ||
                              int'(out_byte_count) != tbl[k].ecnt)) ok = 0;
            if (tbl[k].dchk && out_data !== tbl[k].edata) ok = 0;
            tests++;
            if (!ok) begin
                fails++;
                $display("FAIL tbl[%0d] got soc=%0b eoc=%0b err=%0b dv=%0b data=%02h bits=%0d cnt=%0d exp soc=%0b eoc=%0b err=%0b dv=%0b data=%02h bits=%0d cnt=%0d",
                         k, out_soc, out_eoc, out_error, out_data_valid, out_data,
                         out_data_bits, out_byte_count, tbl[k].es, tbl[k].ee, tbl[k].eer,
                         tbl[k].edv, tbl[k].edata, tbl[k].ebits, tbl[k].ecnt);
            end
        end

        // Standard frame
        clr_ev();
        tick(1, 0, 0, 0, 0);
        send_byte(8'h93, 1);
        send_byte(8'h20, 0);
        tick(0, 1, 0, 0, 0);
        check("std_dv_count", n_dv, 2);
        check("std_byte0", (dv_q.size() > 0) ? int'(dv_q[0]) : -1, 8'h93);
        check("std_byte1", (dv_q.size() > 1) ? int'(dv_q[1]) : -1, 8'h20);
        check("std_eoc_bits", last_bits, 0);
        check("std_eoc_count", last_cnt, 2);

        // Parity failure
        clr_ev();
        tick(1, 0, 0, 0, 0);
        send_byte(8'h93, 0);
        send_byte(8'h20, 0);
        tick(0, 1, 0, 0, 0);
        check("par_err_count", n_err, 1);
        check("par_dv_count", n_dv, 0);
        check("par_eoc_count", n_eoc, 1);
        check("par_byte_count", last_cnt, 0);

        // Timing error mid-byte
        clr_ev();
        tick(1, 0, 0, 0, 0);
        send_bits(8'h0F, 4);
        tick(0, 0, 1, 0, 0);
        send_bits(8'hA5, 8);
        send_bits(8'h03, 2);
        tick(0, 1, 0, 0, 0);
        check("terr_err_count", n_err, 1);
        check("terr_eoc_count", n_eoc, 1);
        check("terr_dv_count", n_dv, 0);
        check("terr_eoc_bits", last_bits, 0);

        // Byte count saturation
        clr_ev();
        tick(1, 0, 0, 0, 0);
        for (int i = 0; i < 70; i++) begin
            logic [7:0] b;
            b = 8'($urandom);
            send_byte(b, ~^b);
        end
        tick(0, 1, 0, 0, 0);
        check("sat_dv_count", n_dv, 70);
        check("sat_byte_count", last_cnt, 63);

        // eoc right after the 8th bit
        clr_ev();
        tick(1, 0, 0, 0, 0);
        send_byte(8'h55, 1);
        send_bits(8'hC3, 8);
        tick(0, 1, 0, 0, 0);
        check("eoc_after_8th_err_eoc", int'(saw_err_eoc), 1);
        check("eoc_after_8th_count", last_cnt, 1);

        // Reset mid-frame, then traffic without soc
        tick(1, 0, 0, 0, 0);
        send_byte(8'h12, ~^8'h12);
        send_bits(8'h07, 3);
        @(negedge clk);
        rst_n = 0;
        #1;
        check("midframe_reset_immediate", all_outs(), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1;
        clr_ev();
        send_bits(8'hFF, 8);
        send_bits(8'h01, 2);
        tick(0, 1, 0, 0, 0);
        check("post_reset_events", n_soc + n_eoc + n_err + n_dv, 0);
        check("post_reset_outputs", all_outs(), 0);

        // Randomized stream against the reference model
        for (int i = 0; i < 3000; i++) begin
            s  = ($urandom_range(0, 99) < 3);
            er = ($urandom_range(0, 99) < 2);
            e  = ($urandom_range(0, 99) < 4);
            v  = ($urandom_range(0, 99) < 70);
            d  = 1'($urandom_range(0, 1));
            if (m_act && mq.size() == 8 && $urandom_range(0, 9) != 0) begin
                ones = 0;
                foreach (mq[j]) ones += mq[j];
                d = (ones % 2 == 0);
            end
            tick(s, e, er, v, d);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
